// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-wait freeze with timeout.
// Optional build macro HAZARD_PERF_EN adds the stall_count performance counter output.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] Rs1_ID,
    input  logic [4:0] Rs2_ID,
    input  logic [4:0] Rd_EX,
    input  logic       MemRead_EX,
    input  logic       Branch_taken_EX,
    input  logic       mem_req_MEM,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       ID_EX_Bubble,
    output logic       IF_ID_Flush,
    output logic       Pipe_Freeze,
    output logic       mem_error
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_count
`endif
);

    // state    | meaning
    // RUN      | normal issue; load-use and branch hazards resolved here
    // MEM_WAIT | data memory busy; whole pipeline frozen, hazard inputs ignored
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;
    logic       load_use;
    logic       mem_stall;
    logic       set_err;

    assign load_use  = MemRead_EX && (Rd_EX != 5'd0) &&
                       ((Rd_EX == Rs1_ID) || (Rd_EX == Rs2_ID));
    assign mem_stall = mem_req_MEM && !mem_ready;
    assign wait_next = wait_cnt + 8'd1;

    always_comb begin
        state_d      = state_q;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;
        set_err      = 1'b0;
        if (RESET) begin
            // Hold fetch and squash whatever sits in IF/ID and ID/EX.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            IF_ID_Flush  = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        Pipe_Freeze = 1'b1;
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        state_d     = MEM_WAIT;
                    end else if (Branch_taken_EX) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if (load_use) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    Pipe_Freeze = 1'b1;
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    // A late ready on the final allowed cycle still counts as success.
                    if (mem_ready) begin
                        state_d = RUN;
                    end else if (wait_next == TIMEOUT_CNT) begin
                        state_d = RUN;
                        set_err = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= RUN;
            wait_cnt  <= 8'd0;
            mem_error <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_q == RUN) ? 8'd0 : wait_next;
            if (set_err) begin
                mem_error <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_count <= 32'd0;
        end else if (!PCWrite && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios then randomized traffic
// compared against a behavioural model of the pipeline-control rules.
module tb_hazard_control_unit;

    localparam int unsigned TIMEOUT = 4;

    logic       CLK;
    logic       RESET;
    logic [4:0] Rs1_ID;
    logic [4:0] Rs2_ID;
    logic [4:0] Rd_EX;
    logic       MemRead_EX;
    logic       Branch_taken_EX;
    logic       mem_req_MEM;
    logic       mem_ready;
    logic       PCWrite;
    logic       IF_ID_Write;
    logic       ID_EX_Bubble;
    logic       IF_ID_Flush;
    logic       Pipe_Freeze;
    logic       mem_error;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: whether memory is still outstanding, how long it has waited,
    // the sticky error, and cycles spent with the PC held.
    bit     m_waiting;
    int     m_waited;
    bit     m_err;
    longint m_stalls;

    hazard_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Rs1_ID         (Rs1_ID),
        .Rs2_ID         (Rs2_ID),
        .Rd_EX          (Rd_EX),
        .MemRead_EX     (MemRead_EX),
        .Branch_taken_EX(Branch_taken_EX),
        .mem_req_MEM    (mem_req_MEM),
        .mem_ready      (mem_ready),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .IF_ID_Flush    (IF_ID_Flush),
        .Pipe_Freeze    (Pipe_Freeze),
        .mem_error      (mem_error)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze}.
    function automatic logic [4:0] expected_ctl();
        bit hazard;
        hazard = MemRead_EX && (Rd_EX != 0) && (Rd_EX == Rs1_ID || Rd_EX == Rs2_ID);
        if (RESET)                              return 5'b00110;
        if (m_waiting)                          return 5'b00001;
        if (mem_req_MEM && !mem_ready)          return 5'b00001;
        if (Branch_taken_EX)                    return 5'b11110;
        if (hazard)                             return 5'b00100;
        return 5'b11000;
    endfunction

    // One clock: drive after the falling edge, check mid-cycle, advance the model at the rising edge.
    task automatic step(input bit rst, input int rs1, input int rs2, input int rd,
                        input bit mr, input bit br, input bit req, input bit rdy,
                        input string tag);
        logic [4:0] exp_ctl;
        @(negedge CLK);
        RESET           = rst;
        Rs1_ID          = 5'(rs1);
        Rs2_ID          = 5'(rs2);
        Rd_EX           = 5'(rd);
        MemRead_EX      = mr;
        Branch_taken_EX = br;
        mem_req_MEM     = req;
        mem_ready       = rdy;
        #1;
        if (rst) begin
            m_waiting = 0;
            m_waited  = 0;
            m_err     = 0;
            m_stalls  = 0;
        end
        exp_ctl = expected_ctl();
        check({tag, "_ctl"}, 32'({PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze}),
              32'(exp_ctl));
        check({tag, "_err"}, 32'(mem_error), 32'(m_err));
`ifdef HAZARD_PERF_EN
        check({tag, "_stalls"}, stall_count, 32'(m_stalls));
`endif
        @(posedge CLK);
        if (!rst) begin
            if (!exp_ctl[4] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            if (m_waiting) begin
                m_waited++;
                if (rdy) begin
                    m_waiting = 0;
                end else if (m_waited == TIMEOUT) begin
                    m_waiting = 0;
                    m_err     = 1;
                end
            end else if (req && !rdy) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
    endtask

    task automatic idle(input string tag);
        step(0, 1, 2, 3, 0, 0, 0, 0, tag);
    endtask

    initial begin
        RESET = 1'b1;
        Rs1_ID = '0; Rs2_ID = '0; Rd_EX = '0;
        MemRead_EX = 0; Branch_taken_EX = 0; mem_req_MEM = 0; mem_ready = 0;
        m_waiting = 0; m_waited = 0; m_err = 0; m_stalls = 0;

        step(1, 5, 5, 5, 1, 1, 1, 0, "reset_hold");
        step(1, 0, 0, 0, 0, 0, 0, 0, "reset_hold2");
        idle("first_run");

        step(0, 7, 5, 5, 1, 0, 0, 0, "load_use_rs2");
        idle("load_use_release");
        step(0, 5, 9, 5, 1, 0, 0, 0, "load_use_rs1");
        step(0, 0, 4, 0, 1, 0, 0, 0, "x0_no_hazard");
        step(0, 5, 5, 5, 0, 0, 0, 0, "no_memread");
        step(0, 5, 5, 5, 1, 1, 0, 0, "branch_over_lu");
        step(0, 5, 5, 5, 1, 1, 1, 1, "req_ready_same");

        // Memory wait: three low-ready cycles then ready.
        step(0, 5, 5, 5, 1, 1, 1, 0, "mw_enter");
        step(0, 5, 5, 5, 1, 1, 1, 0, "mw_wait1");
        step(0, 5, 5, 5, 1, 1, 1, 0, "mw_wait2");
        step(0, 5, 5, 5, 1, 1, 1, 1, "mw_ready");
        step(0, 5, 5, 5, 1, 0, 0, 0, "mw_rerun_lu");

        // Ready arriving on the last allowed wait cycle is a success.
        step(0, 1, 1, 1, 0, 0, 1, 0, "edge_enter");
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 1, 1, 1, 0, 0, 1, 0, "edge_wait");
        step(0, 1, 1, 1, 0, 0, 1, 1, "edge_ready");
        idle("edge_after");

        // Timeout: error sets, RUN resumes, flag sticky.
        step(0, 2, 2, 2, 1, 0, 1, 0, "to_enter");
        for (int i = 0; i < TIMEOUT; i++) step(0, 2, 2, 2, 1, 1, 1, 0, "to_wait");
        idle("to_resumed");
        step(0, 2, 3, 2, 1, 0, 0, 0, "to_sticky_lu");
        idle("to_sticky");

        // Reset pulsed in the middle of a wait.
        step(0, 1, 1, 1, 0, 0, 1, 0, "rst_mw_enter");
        step(0, 1, 1, 1, 0, 0, 1, 0, "rst_mw_wait");
        step(1, 1, 1, 1, 0, 0, 1, 0, "rst_mw_pulse");
        idle("rst_mw_after");

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 149) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
